// File: rtl/tetris_pkg.sv
// tetris_pkg: playfield bounds, line-clear FSM states, cell addressing and score table
package tetris_pkg;
  localparam int PF_X_LEFT = 10;
  localparam int PF_X_RIGHT = 19;
  localparam int PF_Y_TOP = 5;
  localparam int PF_Y_BOT = 24;
  localparam int PF_RD_LAT = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_EVAL, S_SH_RD, S_SH_WAIT, S_SH_WR, S_CLEAR, S_FINISH
  } state_t;
  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return {row, col};
  endfunction
  function automatic logic [15:0] score_of(input logic [2:0] lines);
    return lines == 3'd1 ? 16'd40 : lines == 3'd2 ? 16'd100 :
           lines == 3'd3 ? 16'd300 : lines == 3'd4 ? 16'd1200 : 16'd0;
  endfunction
endpackage

// File: rtl/tetris_score_acc.sv
// tetris_score_acc: saturating score accumulator fed by the lines-per-run table
module tetris_score_acc
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        add,
  input  logic [2:0]  lines,
  output logic [15:0] score
);
  logic [16:0] sum;
  assign sum = {1'b0, score} + {1'b0, score_of(lines)};
  // accumulate once per finished run, clamping at full scale
  always_ff @(posedge clk or negedge rst)
    if (!rst) score <= '0;
    else if (add) score <= sum[16] ? 16'hFFFF : sum[15:0];
endmodule

// File: rtl/tetris_line_clear.sv
// tetris_line_clear: scans the playfield for full rows and collapses them (score via TETRIS_SCORE_EN)
module tetris_line_clear
  import tetris_pkg::*;
#(
  parameter int X_LEFT  = PF_X_LEFT,
  parameter int X_RIGHT = PF_X_RIGHT,
  parameter int Y_TOP   = PF_Y_TOP,
  parameter int Y_BOT   = PF_Y_BOT,
  parameter int RD_LAT  = PF_RD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [2:0]  lines_cleared,
  output logic [15:0] score,
  output logic [10:0] rd_addr,
  input  logic [5:0]  rd_data,
  output logic [10:0] wr_addr,
  output logic        wr_en,
  output logic [5:0]  wr_data
);
  localparam logic [5:0] XL = 6'(X_LEFT);
  localparam logic [5:0] LAST = 6'(X_RIGHT - X_LEFT);
  localparam logic [4:0] YT = 5'(Y_TOP);
  localparam logic [4:0] YB = 5'(Y_BOT);
  localparam logic [3:0] WLAST = 4'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  state_t state, state_nxt;
  logic [4:0] r, k;
  logic [5:0] col, samp;
  logic [3:0] w;
  logic [RD_LAT-1:0] pv;
  logic [2:0] cnt;
  logic full, issue, smp;
  assign issue = state == S_SCAN && col <= LAST;
  assign smp = state == S_SCAN && pv[RD_LAT-1];
  // state register; reset aborts any run at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_nxt;
  // next state and RAM write port, driven from the current state so writes stop with reset
  always_comb begin
    state_nxt = state;
    wr_en = state == S_SH_WR || state == S_CLEAR;
    wr_addr = wr_en ? cell_addr(state == S_CLEAR ? YT : k, XL + col) : '0;
    wr_data = state == S_SH_WR ? rd_data : '0;
    unique case (state)
      S_IDLE:    state_nxt = start ? S_SCAN : S_IDLE;
      S_SCAN:    state_nxt = smp && samp == LAST ? S_EVAL : S_SCAN;
      S_EVAL:    state_nxt = !full ? (r == YT ? S_FINISH : S_SCAN) : (r == YT ? S_CLEAR : S_SH_RD);
      S_SH_RD:   state_nxt = RD_LAT > 1 ? S_SH_WAIT : S_SH_WR;
      S_SH_WAIT: state_nxt = w == WLAST ? S_SH_WR : S_SH_WAIT;
      S_SH_WR:   state_nxt = col == LAST && k == YT + 5'd1 ? S_CLEAR : S_SH_RD;
      S_CLEAR:   state_nxt = col == LAST ? S_SCAN : S_CLEAR;
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end
  // row/column pointers, read pipeline tracking and run bookkeeping
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      lines_cleared <= '0;
      rd_addr <= '0;
      r <= '0;
      k <= '0;
      col <= '0;
      samp <= '0;
      w <= '0;
      pv <= '0;
      cnt <= '0;
      full <= 1'b0;
    end else begin
      done <= 1'b0;
      pv <= RD_LAT'({pv, issue});
      if (issue) begin
        rd_addr <= cell_addr(r, XL + col);
        col <= col + 6'd1;
      end
      if (smp) begin
        full <= full & (rd_data != '0);
        samp <= samp + 6'd1;
      end
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          r <= YB;
          cnt <= '0;
          col <= '0;
          samp <= '0;
          full <= 1'b1;
        end
        S_EVAL: begin
          col <= '0;
          samp <= '0;
          full <= 1'b1;
          k <= r;
          if (!full && r != YT) r <= r - 5'd1;
        end
        S_SH_RD: begin
          rd_addr <= cell_addr(k - 5'd1, XL + col);
          w <= '0;
        end
        S_SH_WAIT: w <= w + 4'd1;
        S_SH_WR: begin
          col <= col == LAST ? '0 : col + 6'd1;
          if (col == LAST) k <= k - 5'd1;
        end
        S_CLEAR: begin
          col <= col == LAST ? '0 : col + 6'd1;
          if (col == LAST) begin
            cnt <= cnt == 3'd4 ? 3'd4 : cnt + 3'd1;
            samp <= '0;
            full <= 1'b1;
          end
        end
        S_FINISH: begin
          lines_cleared <= cnt;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
`ifdef TETRIS_SCORE_EN
  tetris_score_acc u_score (
    .clk(clk),
    .rst(rst),
    .add(state == S_FINISH),
    .lines(cnt),
    .score(score)
  );
`else
  assign score = '0;
`endif
endmodule

// File: doc/tetris_line_clear.md
Name: tetris_line_clear

Overview:
- Downstream stage of the Tetris game engine.
- After the engine locks a piece, this block scans the playfield in the shared 64x32 cell RAM (6-bit colour per cell, 0 = empty) for completed rows.
- Each full row is removed by copying every row above it down by one, then clearing the top row.
- Reports lines cleared and a running score; asserts busy so the engine stalls its move sequencer.

Parameters:
- X_LEFT, 10, leftmost playfield column (inclusive)
- X_RIGHT, 19, rightmost playfield column (inclusive)
- Y_TOP, 5, top playfield row (inclusive)
- Y_BOT, 24, bottom playfield row (inclusive)
- RD_LAT, 2, clocks from rd_addr register update to matching rd_data being valid

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse from the engine at piece lock
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the scan completes
- lines_cleared  output  3  rows removed by the last run (0..4), held until next start
- score  output  16  accumulated score
- rd_addr  output  11  {row[4:0], col[5:0]} RAM read address
- rd_data  input  6  RAM read data
- wr_addr  output  11  {row[4:0], col[5:0]} RAM write address
- wr_en  output  1  RAM write strobe
- wr_data  output  6  RAM write data

Behaviour:
- Reset values: busy=0, done=0, lines_cleared=0, score=0, rd_addr=0, wr_addr=0, wr_en=0, wr_data=0, FSM=IDLE.
- IDLE:
  - start=1 latches row r=Y_TOP..Y_BOT index pointer to Y_BOT, clears run count, goes SCAN.
  - start is ignored while busy.
- SCAN:
  - Issue reads for cols X_LEFT..X_RIGHT of row r, one address per clock.
  - Each rd_data is sampled RD_LAT clocks after its address.
  - full flag = AND of (rd_data != 0) over all 10 cells.
  - After the last sample, go EVAL.
- EVAL:
  - full=1: go SHIFT with k=r.
  - full=0 and r==Y_TOP: go FINISH.
  - full=0 otherwise: r<=r-1, go SCAN.
- SHIFT, per cell, 3-state sub-sequence RD -> WAIT(RD_LAT-1) -> WR:
  - Read (k-1,c), then write the same data to (k,c) with wr_en high exactly 1 clock.
  - Columns ascend; rows k from r down to Y_TOP+1.
  - Then go CLEAR.
- CLEAR:
  - Write 0 to (Y_TOP,c) for all 10 columns, 1 clock each.
  - Increment run count, saturating at 4.
  - Return to SCAN with r unchanged, so the row shifted into r is re-examined.
- FINISH:
  - lines_cleared <= run count.
  - score update (see Optional Feature).
  - done=1 for 1 clock; busy deasserts in the same clock; return to IDLE.
- Simultaneous read and write in one clock is never issued: the RAM sees at most one new access per clock.
- wr_en is never high outside SHIFT/CLEAR.
- Row arithmetic is 5-bit with no wrap; r never goes below Y_TOP.
- Reset mid-operation aborts immediately with wr_en=0. RAM contents may be partially shifted; the engine restarts the game.
- A full top row Y_TOP is cleared by CLEAR alone (no SHIFT rows).

Optional Feature:
- Macro: TETRIS_SCORE_EN.
- Defined: at FINISH, score <= score + table[run count], table = 0, 40, 100, 300, 1200. The add saturates at 16'hFFFF.
- Undefined: score is tied to 0; no adder or table is synthesised. lines_cleared still operates.

Decomposition:
- Package tetris_pkg:
  - playfield bound constants
  - FSM state enum
  - cell address pack function {row, col}
  - score table constant
- One sub-module, tetris_score_acc: saturating accumulator plus table lookup, instantiated only under TETRIS_SCORE_EN.

Test Plan:
- Empty field, start pulse:
  - exactly 20 row scans, no wr_en
  - done after ≈20*(10+RD_LAT) clocks
  - lines_cleared=0, score=0
- Row 24 all colour 1, cell (23,12)=3:
  - row 24 cleared; (24,12)=3
  - row 23 becomes a copy of row 22
  - lines_cleared=1, score=40
- Rows 21..24 full, all else empty:
  - all four removed, field empty
  - lines_cleared=4, score=1200
- Rows 24 and 22 full, row 23 has one hole at col 15:
  - lines_cleared=2
  - final row 24 = old row 23 (hole at 15), row 23 = old row 21
  - score=100
- start pulsed again while busy:
  - ignored; single done pulse
  - behaviour identical to a single start
- rst low during SHIFT: wr_en=0 and busy=0 in the same cycle (async); a new start after release runs normally.
